pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage ARM pipeline (IF, ID, EX, MEM, WB). It keeps a shadow scoreboard of destination registers for instructions in EX, MEM and WB. From that it drives the PC and IF_ID enables, the ID-stage NOP-insert select of the control-signal mux, the IF_ID flush for taken branches, and the operand forwarding selects. It sits beside the ControlUnit and pipeline registers and replaces the hand-driven `select` and tied-high enables used in the current pipeline bring-up.

## Interface
- CNT_W, 16, width of the saturating stall and flush event counters
- Clk  in  1  pipeline clock, all state updates on rising edge
- Reset  in  1  asynchronous, active-low reset; one clock domain (Clk) only
- ID_Rn, ID_Rm, ID_Rd  in  4 each  register fields of the instruction in ID
- ID_use_Rn, ID_use_Rm, ID_use_Rd  in  1 each  operand actually read (ID_use_Rd = store data source)
- ID_RF_enable  in  1  ID instruction writes Rd
- ID_load_instr  in  1  ID instruction is a load
- ID_branch_taken  in  1  B/BL in ID resolved taken this cycle
- PC_enable  out  1  PC load enable
- IF_ID_enable  out  1  IF_ID register load enable
- IF_ID_flush  out  1  IF_ID loads a NOP (all-zero instruction) on next edge
- NOP_select  out  1  1 = mux forces all ID control signals to 0 into ID_EX
- ForwardA, ForwardB, ForwardC  out  2 each  source for Rn/Rm/Rd operand: 00 RF, 01 EX result, 10 MEM result, 11 WB result
- stall_count, flush_count  out  CNT_W each  saturating event counters

## Operation
- Scoreboard slots EX, MEM, WB each hold {valid, Rd, RF_enable, load}. On every edge MEM<=EX and WB<=MEM.
- EX<=ID info when NOP_select=0. Otherwise EX is marked invalid.
- Register 15 is never forwarded and never causes a stall.
- Match(slot, r): slot valid, slot RF_enable=1, slot Rd==r, r!=15.
- Forward select per operand, priority EX > MEM > WB, else 00. It is evaluated only when the corresponding ID_use_* is 1, else 00.
- Load-use hazard: EX slot load=1 and Match(EX, r) for any used operand r. EX-slot forwarding is never selected for a load.
- FSM states: RUN, LU_STALL, BR_FLUSH.
- RUN, hazard: PC_enable=0, IF_ID_enable=0, NOP_select=1; next state LU_STALL; stall_count+1.
- RUN, no hazard, ID_branch_taken=1: IF_ID_flush=1, PC and IF_ID enabled; next state BR_FLUSH; flush_count+1.
- RUN, otherwise: all enables 1, NOP_select=0, flush 0; stay RUN.
- LU_STALL: the load is now in MEM, and the dependent operand selects 10 by normal priority. Hazard evaluation repeats normally, but a back-to-back stall on the same load is impossible. The exit transition follows the RUN rules.
- BR_FLUSH: the ID slot holds the flushed bubble. Hazards and ID_branch_taken are ignored, NOP_select=1, enables 1. Next state RUN.
- Simultaneous hazard and taken branch: the stall wins. The branch is re-presented and taken on the following cycle.
- Counters saturate at all-ones and never wrap.

## Timing
- Reset low (any time, asynchronous): state RUN, all scoreboard slots invalid, counters 0, PC_enable=1, IF_ID_enable=1, IF_ID_flush=0, NOP_select=0, all Forward*=00. Outputs are forced to these values while Reset is low, regardless of ID inputs.
- Reset deassertion mid-stall: the pipeline resumes in RUN with an empty scoreboard. There is no leftover stall.
- Stall, flush and NOP outputs are combinational from state, scoreboard and ID inputs within the same cycle. Scoreboard, FSM and counters update on the rising Clk edge.
- Load-use penalty: exactly 1 cycle. Taken-branch penalty: exactly 1 bubble.
- Forwarding selects are valid in the same cycle the consumer is in ID.

## Test plan
- Reset: hold Reset=0 for 2 cycles with random ID inputs -> enables 1, NOP_select 0, Forward* 00, counters 0. Release -> state RUN.
- ALU chain: ADD R1 (ID_RF_enable=1, Rd=1), then SUB using Rn=1, then ORR using Rm=1, then AND using Rd=1 store source -> ForwardA=01, then ForwardB=10, then ForwardC=11. No stalls.
- Load-use: LDR R2, then ADD Rn=2 -> one cycle with PC_enable=0, IF_ID_enable=0, NOP_select=1. Next cycle ForwardA=10, state RUN. stall_count=1.
- Taken branch: B with ID_branch_taken=1 and no hazard -> IF_ID_flush=1 for one cycle. Next cycle NOP_select=1 in BR_FLUSH, then RUN. flush_count=1.
- Priority and R15: load-use coincident with ID_branch_taken=1 -> stall first, flush next cycle. An instruction reading R15 after a write to R15 -> Forward=00, no stall.
- Saturation and async reset: force 70000 stalls with CNT_W=16 -> stall_count holds 65535. Pull Reset low mid-LU_STALL -> outputs revert immediately and counters clear.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the ID stage / pipeline registers and the hazard controller.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       ID_Rn, ID_Rm, ID_Rd;
    logic             ID_use_Rn, ID_use_Rm, ID_use_Rd;
    logic             ID_RF_enable, ID_load_instr, ID_branch_taken;
    logic             PC_enable, IF_ID_enable, IF_ID_flush, NOP_select;
    logic [1:0]       ForwardA, ForwardB, ForwardC;
    logic [CNT_W-1:0] stall_count, flush_count;

    modport master (
        output ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_RF_enable, ID_load_instr, ID_branch_taken,
        input  PC_enable, IF_ID_enable, IF_ID_flush, NOP_select,
               ForwardA, ForwardB, ForwardC, stall_count, flush_count
    );

    modport slave (
        input  ID_Rn, ID_Rm, ID_Rd, ID_use_Rn, ID_use_Rm, ID_use_Rd,
               ID_RF_enable, ID_load_instr, ID_branch_taken,
        output PC_enable, IF_ID_enable, IF_ID_flush, NOP_select,
               ForwardA, ForwardB, ForwardC, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: destination scoreboard,
// load-use stall, taken-branch flush, operand forwarding selects and event counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic                   Clk,
    input logic                   Reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {RUN, LU_STALL, BR_FLUSH} state_e;

    typedef struct packed {
        logic       valid;
        logic [3:0] rd;
        logic       rf_en;
        logic       load;
    } slot_t;

    state_e           state_q, state_d;
    slot_t            ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d, flush_count_q, flush_count_d;

    logic       pc_enable, if_id_enable, if_id_flush, nop_select, hazard;
    logic [1:0] fwd_a, fwd_b, fwd_c;

    function automatic logic match(input slot_t s, input logic [3:0] r);
        return s.valid && s.rf_en && (s.rd == r) && (r != 4'd15);
    endfunction

    // A load still in EX has no data yet, so its slot is passed over for older producers.
    function automatic logic [1:0] fwd_sel(input logic used, input logic [3:0] r,
                                           input slot_t ex, input slot_t mem, input slot_t wb);
        if (!used)                    return 2'b00;
        if (match(ex, r) && !ex.load) return 2'b01;
        if (match(mem, r))            return 2'b10;
        if (match(wb, r))             return 2'b11;
        return 2'b00;
    endfunction

    assign hazard = ex_q.load && ((hz.ID_use_Rn && match(ex_q, hz.ID_Rn)) ||
                                  (hz.ID_use_Rm && match(ex_q, hz.ID_Rm)) ||
                                  (hz.ID_use_Rd && match(ex_q, hz.ID_Rd)));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path infers a latch.
        state_d       = state_q;
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        if_id_flush   = 1'b0;
        nop_select    = 1'b0;
        fwd_a         = fwd_sel(hz.ID_use_Rn, hz.ID_Rn, ex_q, mem_q, wb_q);
        fwd_b         = fwd_sel(hz.ID_use_Rm, hz.ID_Rm, ex_q, mem_q, wb_q);
        fwd_c         = fwd_sel(hz.ID_use_Rd, hz.ID_Rd, ex_q, mem_q, wb_q);

        case (state_q)
            RUN, LU_STALL: begin
                if (hazard) begin
                    pc_enable     = 1'b0;
                    if_id_enable  = 1'b0;
                    nop_select    = 1'b1;
                    state_d       = LU_STALL;
                    stall_count_d = (stall_count_q == '1) ? stall_count_q
                                                          : stall_count_q + CNT_W'(1);
                end else if (hz.ID_branch_taken) begin
                    if_id_flush   = 1'b1;
                    state_d       = BR_FLUSH;
                    flush_count_d = (flush_count_q == '1) ? flush_count_q
                                                          : flush_count_q + CNT_W'(1);
                end else begin
                    state_d = RUN;
                end
            end
            BR_FLUSH: begin
                nop_select = 1'b1;
                state_d    = RUN;
            end
            default: state_d = RUN;
        endcase

        ex_d  = nop_select ? '0 : '{valid: 1'b1, rd: hz.ID_Rd,
                                    rf_en: hz.ID_RF_enable, load: hz.ID_load_instr};
        mem_d = ex_q;
        wb_d  = mem_q;

        // While Reset is held the pipeline sees a free-running, unforwarded datapath.
        if (!Reset) begin
            pc_enable    = 1'b1;
            if_id_enable = 1'b1;
            if_id_flush  = 1'b0;
            nop_select   = 1'b0;
            fwd_a        = 2'b00;
            fwd_b        = 2'b00;
            fwd_c        = 2'b00;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= RUN;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            ex_q          <= ex_d;
            mem_q         <= mem_d;
            wb_q          <= wb_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign hz.PC_enable    = pc_enable;
    assign hz.IF_ID_enable = if_id_enable;
    assign hz.IF_ID_flush  = if_id_flush;
    assign hz.NOP_select   = nop_select;
    assign hz.ForwardA     = fwd_a;
    assign hz.ForwardB     = fwd_b;
    assign hz.ForwardC     = fwd_c;
    assign hz.stall_count  = stall_count_q;
    assign hz.flush_count  = flush_count_q;

endmodule
